// File: rtl/vga_reg_writer.sv
// vga_reg_writer: buffers game-logic register updates in a FIFO and replays them as
// Avalon-MM writes to the sprite display block, only while the display is in vblank.
// Build macro VGA_REG_WRITER_COALESCE_EN: an update whose address matches the tail entry
// overwrites that entry's data instead of taking a new slot, unless the tail is on the bus.
module vga_reg_writer #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned ADDR_W     = 9,
  parameter int unsigned DATA_W     = 32
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        upd_valid,
  output logic                        upd_ready,
  input  logic [ADDR_W-1:0]           upd_addr,
  input  logic [DATA_W-1:0]           upd_data,
  input  logic                        vblank,
  input  logic                        waitrequest,
  output logic [ADDR_W-1:0]           address,
  output logic [DATA_W-1:0]           writedata,
  output logic                        chipselect,
  output logic                        write,
  input  logic                        clr_overflow,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] CntFull = CntW'(FIFO_DEPTH);

  typedef enum logic [0:0] {StIdle, StWrite} state_e;
  state_e state_q, state_d;

  logic [ADDR_W-1:0] mem_addr_q [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_data_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q, rd_next;
  logic [CntW-1:0]   count_q, count_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic [DATA_W-1:0] writedata_q, writedata_d;
  logic [DATA_W-1:0] head_data, next_data;
  logic              vb_q, overflow_q;
  logic              empty, full, coalesce_hit, push, pop, ovf_set;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntFull);
  assign rd_next = rd_ptr_q + PtrW'(1);

`ifdef VGA_REG_WRITER_COALESCE_EN
  logic [PtrW-1:0] tail_idx;
  logic            tail_on_bus, coalesce_we;
  assign tail_idx     = wr_ptr_q - PtrW'(1);
  assign tail_on_bus  = (state_q == StWrite) && (count_q == CntW'(1));
  assign coalesce_hit = !empty && !tail_on_bus && (upd_addr == mem_addr_q[tail_idx]);
  assign coalesce_we  = upd_valid && coalesce_hit;
  // Bypass so an entry being loaded onto the bus on the same edge it is overwritten
  // carries the new data rather than the stale one.
  assign head_data = (coalesce_we && (tail_idx == rd_ptr_q)) ? upd_data : mem_data_q[rd_ptr_q];
  assign next_data = (coalesce_we && (tail_idx == rd_next)) ? upd_data : mem_data_q[rd_next];
`else
  assign coalesce_hit = 1'b0;
  assign head_data    = mem_data_q[rd_ptr_q];
  assign next_data    = mem_data_q[rd_next];
`endif

  // Readiness is judged on the pre-pop occupancy: a full FIFO refuses even while popping.
  assign upd_ready = !full || coalesce_hit;
  assign push      = upd_valid && upd_ready && !coalesce_hit;
  assign ovf_set   = upd_valid && !upd_ready;
  assign pop       = (state_q == StWrite) && !waitrequest;
  assign count_d   = count_q + CntW'(push) - CntW'(pop);

  assign address    = address_q;
  assign writedata  = writedata_q;
  assign write      = (state_q == StWrite);
  assign chipselect = (state_q == StWrite);
  assign overflow   = overflow_q;
  assign fifo_count = count_q;

  // FIFO storage: new entries at the write pointer, coalesced data into the tail.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr_q[wr_ptr_q] <= upd_addr;
      mem_data_q[wr_ptr_q] <= upd_data;
    end
`ifdef VGA_REG_WRITER_COALESCE_EN
    else if (coalesce_we) begin
      mem_data_q[tail_idx] <= upd_data;
    end
`endif
  end

  // Bus FSM: start only in registered vblank, finish a started write regardless.
  always_comb begin
    state_d     = state_q;
    address_d   = address_q;
    writedata_d = writedata_q;
    case (state_q)
      StIdle: begin
        if (!empty && vb_q) begin
          state_d     = StWrite;
          address_d   = mem_addr_q[rd_ptr_q];
          writedata_d = head_data;
        end
      end
      StWrite: begin
        if (!waitrequest) begin
          if ((count_q > CntW'(1)) && vb_q) begin
            address_d   = mem_addr_q[rd_next];
            writedata_d = next_data;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, pointers, occupancy, vblank sync and sticky overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      address_q   <= '0;
      writedata_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      vb_q        <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      address_q   <= address_d;
      writedata_q <= writedata_d;
      count_q     <= count_d;
      vb_q        <= vblank;
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop) rd_ptr_q <= rd_next;
      if (ovf_set) begin
        overflow_q <= 1'b1;
      end else if (clr_overflow) begin
        overflow_q <= 1'b0;
      end
    end
  end

endmodule
